// File: rtl/touch_event_filter_pkg.sv
// touch_pkg: event, FSM and helper definitions shared by touch_event_filter
package touch_pkg;
    localparam int TOUCH_COORD_W = 12;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_MOVE    = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_type_e;

    typedef struct packed {
        evt_type_e                typ;
        logic [TOUCH_COORD_W-1:0] x;
        logic [TOUCH_COORD_W-1:0] y;
    } touch_evt_t;

    typedef enum logic [1:0] {ST_UP, ST_FIRST, ST_DOWN} touch_state_e;

    function automatic logic [TOUCH_COORD_W-1:0] abs_diff(input logic [TOUCH_COORD_W-1:0] a,
                                                          input logic [TOUCH_COORD_W-1:0] b);
        return a > b ? a - b : b - a;
    endfunction
endpackage

// File: rtl/touch_event_filter_fifo.sv
// touch_evt_fifo: first-word-fall-through FIFO of touch events; pop is evaluated before push
module touch_evt_fifo
    import touch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  touch_evt_t din,
    output touch_evt_t dout,
    output logic       full,
    output logic       empty,
    output logic       drop
);
    localparam int AW = $clog2(DEPTH);

    touch_evt_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_pop, do_push;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/touch_event_filter.sv
// touch_event_filter: pen debounce, sample averaging and PRESS/MOVE/RELEASE event FIFO.
// Define TOUCH_FILTER_MOVE_EN to build MOVE event generation (off by default).
module touch_event_filter
    import touch_pkg::*;
#(
    parameter int COORD_W     = TOUCH_COORD_W,
    parameter int AVG_LOG2    = 2,
    parameter int DEB_CYCLES  = 50000,
    parameter int MOVE_THRESH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               touching,
    input  logic               sample_stb,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_type,
    output logic [COORD_W-1:0] evt_x,
    output logic [COORD_W-1:0] evt_y,
    output logic               overflow,
    input  logic               clear_ovf
);
    localparam int ACC_W = COORD_W + AVG_LOG2;
    localparam int DW    = $clog2(DEB_CYCLES);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MOVE_THRESH < 0) begin : g_bad_cfg
        $error("touch_event_filter: invalid parameters");
    end

    touch_state_e       state, state_nxt;
    logic               level, flip, rise, fall, take, done, moved, push, drop, full, empty;
    logic [DW-1:0]      deb_cnt;
    logic [AVG_LOG2-1:0] samp_cnt;
    logic [ACC_W-1:0]   acc_x, acc_y, sum_x, sum_y;
    logic [COORD_W-1:0] avg_x, avg_y, last_x, last_y;
    touch_evt_t         push_evt, head;

    // flip marks the cycle on which the accepted level changes; FSM reacts on the same edge
    assign flip  = touching != level && deb_cnt == DW'(DEB_CYCLES - 1);
    assign rise  = flip && !level;
    assign fall  = flip && level;
    assign take  = sample_stb && state != ST_UP && !fall;
    assign done  = take && &samp_cnt;
    assign sum_x = acc_x + ACC_W'(x_in);
    assign sum_y = acc_y + ACC_W'(y_in);
    assign avg_x = sum_x[ACC_W-1:AVG_LOG2];
    assign avg_y = sum_y[ACC_W-1:AVG_LOG2];

`ifdef TOUCH_FILTER_MOVE_EN
    assign moved = abs_diff(avg_x, last_x) > COORD_W'(MOVE_THRESH) ||
                   abs_diff(avg_y, last_y) > COORD_W'(MOVE_THRESH);
`else
    assign moved = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_evt  = '0;
        case (state)
            ST_UP: if (rise) state_nxt = ST_FIRST;
            ST_FIRST:
                if (fall) state_nxt = ST_UP;
                else if (done) begin
                    state_nxt = ST_DOWN;
                    push      = 1'b1;
                    push_evt  = '{typ: EVT_PRESS, x: avg_x, y: avg_y};
                end
            ST_DOWN:
                if (fall) begin
                    state_nxt = ST_UP;
                    push      = 1'b1;
                    push_evt  = '{typ: EVT_RELEASE, x: last_x, y: last_y};
                end else if (done && moved) begin
                    push     = 1'b1;
                    push_evt = '{typ: EVT_MOVE, x: avg_x, y: avg_y};
                end
            default: state_nxt = ST_UP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_UP;
            level    <= 1'b0;
            deb_cnt  <= '0;
            samp_cnt <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            last_x   <= '0;
            last_y   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (touching == level) deb_cnt <= '0;
            else if (flip) begin
                deb_cnt <= '0;
                level   <= touching;
            end else deb_cnt <= deb_cnt + 1'b1;
            if (flip || done) begin
                samp_cnt <= '0;
                acc_x    <= '0;
                acc_y    <= '0;
            end else if (take) begin
                samp_cnt <= samp_cnt + 1'b1;
                acc_x    <= sum_x;
                acc_y    <= sum_y;
            end
            if (push && push_evt.typ != EVT_RELEASE) begin
                last_x <= avg_x;
                last_y <= avg_y;
            end
            if (drop) overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

    touch_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (evt_ready),
        .din   (push_evt),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    assign evt_valid = !empty;
    assign evt_type  = head.typ;
    assign evt_x     = head.x;
    assign evt_y     = head.y;
endmodule

// File: tb/tb_touch_event_filter.sv
// tb_touch_event_filter: table-driven and scoreboarded checks of touch_event_filter
module tb_touch_event_filter;
    import touch_pkg::*;

    localparam int DEB = 50;
`ifdef TOUCH_FILTER_MOVE_EN
    localparam bit MOVE_EN = 1'b1;
`else
    localparam bit MOVE_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, touching = 1'b0, sample_stb = 1'b0;
    logic        evt_ready = 1'b0, clear_ovf = 1'b0;
    logic [11:0] x_in = '0, y_in = '0, evt_x, evt_y;
    logic        evt_valid, overflow;
    logic [1:0]  evt_type;

    int          n_cmp = 0, n_bad = 0, valid_seen = 0, vs0;
    touch_evt_t  exp_q[$];
    touch_evt_t  mon_e;
    logic [11:0] last_x, last_y;

    typedef struct {
        logic [3:0][11:0] xs;
        logic [3:0][11:0] ys;
        bit               mv;
        logic [11:0]      ex;
        logic [11:0]      ey;
    } vec_t;
    vec_t vec[6];

    touch_event_filter #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .touching(touching), .sample_stb(sample_stb),
        .x_in(x_in), .y_in(y_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_x(evt_x), .evt_y(evt_y),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [11:0] x, input logic [11:0] y);
        sample_stb = 1'b1; x_in = x; y_in = y;
        tick();
        sample_stb = 1'b0;
        tick();
    endtask

    task automatic set_touch(input logic v);
        touching = v;
        tick(DEB + 2);
    endtask

    task automatic expect_evt(input evt_type_e t, input logic [11:0] x, input logic [11:0] y);
        touch_evt_t e;
        e.typ = t; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    // scoreboard: every accepted head must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && evt_valid) begin
            valid_seen++;
            if (evt_ready) begin
                chk("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("evt_type", evt_type, mon_e.typ);
                    chk("evt_x", evt_x, mon_e.x);
                    chk("evt_y", evt_y, mon_e.y);
                end
            end
        end
    end

    initial begin
        vec[0] = '{xs: '{12'd108, 12'd110, 12'd112, 12'd110}, ys: '{4{12'd200}}, mv: 0, ex: 12'd110, ey: 12'd200};
        vec[1] = '{xs: '{12'd118, 12'd120, 12'd122, 12'd121}, ys: '{12'd204, 12'd205, 12'd206, 12'd206}, mv: 1, ex: 12'd120, ey: 12'd205};
        vec[2] = '{xs: '{4{12'd120}}, ys: '{12'd214, 12'd213, 12'd213, 12'd213}, mv: 0, ex: 12'd120, ey: 12'd213};
        vec[3] = '{xs: '{4{12'd120}}, ys: '{4{12'd214}}, mv: 1, ex: 12'd120, ey: 12'd214};
        vec[4] = '{xs: '{12'd111, 12'd111, 12'd111, 12'd112}, ys: '{4{12'd214}}, mv: 1, ex: 12'd111, ey: 12'd214};
        vec[5] = '{xs: '{4{12'd103}}, ys: '{4{12'd222}}, mv: 0, ex: 12'd103, ey: 12'd222};

        tick(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_x", evt_x, 0);
        chk("rst_y", evt_y, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0; evt_ready = 1'b1;
        tick(200);
        chk("idle_no_evt", valid_seen, 0);

        touching = 1'b1; tick(DEB - 10);
        touching = 1'b0; tick(5);
        repeat (4) strobe(12'd500, 12'd500);
        tick(3);
        chk("glitch_no_evt", valid_seen, 0);

        evt_ready = 1'b0;
        set_touch(1'b1);
        strobe(12'd100, 12'd200); strobe(12'd102, 12'd200); strobe(12'd104, 12'd200);
        expect_evt(EVT_PRESS, 12'd103, 12'd200);
        sample_stb = 1'b1; x_in = 12'd106; y_in = 12'd200;
        chk("press_not_early", evt_valid, 0);
        tick();
        sample_stb = 1'b0;
        chk("press_latency", evt_valid, 1);
        chk("press_head_x", evt_x, 103);
        evt_ready = 1'b1;
        tick(2);
        chk("press_drained", exp_q.size(), 0);

        last_x = 12'd103; last_y = 12'd200;
        foreach (vec[i]) begin
            if (vec[i].mv && MOVE_EN) begin
                expect_evt(EVT_MOVE, vec[i].ex, vec[i].ey);
                last_x = vec[i].ex; last_y = vec[i].ey;
            end
            for (int k = 0; k < 4; k++) strobe(vec[i].xs[k], vec[i].ys[k]);
            tick(2);
            chk($sformatf("row%0d_drained", i), exp_q.size(), 0);
        end

        // fourth sample lands on the release edge and must be ignored
        strobe(12'd400, 12'd400); strobe(12'd400, 12'd400); strobe(12'd400, 12'd400);
        expect_evt(EVT_RELEASE, last_x, last_y);
        touching = 1'b0;
        tick(DEB - 1);
        sample_stb = 1'b1; x_in = 12'd400; y_in = 12'd400;
        tick();
        sample_stb = 1'b0;
        tick(5);
        chk("release_drained", exp_q.size(), 0);

        evt_ready = 1'b0;
        set_touch(1'b1);
        expect_evt(EVT_PRESS, 12'd10, 12'd20);
        repeat (4) strobe(12'd10, 12'd20);
        expect_evt(EVT_RELEASE, 12'd10, 12'd20);
        set_touch(1'b0);
        set_touch(1'b1);
        expect_evt(EVT_PRESS, 12'd30, 12'd40);
        repeat (4) strobe(12'd30, 12'd40);
        expect_evt(EVT_RELEASE, 12'd30, 12'd40);
        set_touch(1'b0);
        set_touch(1'b1);
        repeat (3) strobe(12'd50, 12'd60);
        sample_stb = 1'b1; x_in = 12'd50; y_in = 12'd60; clear_ovf = 1'b1;
        tick();
        sample_stb = 1'b0; clear_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("full_valid", evt_valid, 1);
        chk("full_head_type", evt_type, 1);
        chk("full_head_x", evt_x, 10);
        tick(3);
        chk("ovf_sticky", overflow, 1);
        clear_ovf = 1'b1; tick(); clear_ovf = 0;
        chk("ovf_cleared", overflow, 0);

        expect_evt(EVT_RELEASE, 12'd50, 12'd60);
        touching = 1'b0;
        tick(DEB - 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("full_push_pop_no_drop", overflow, 0);
        chk("after_pop_head_type", evt_type, 3);
        chk("after_pop_head_x", evt_x, 10);
        tick(2);
        evt_ready = 1'b1;
        tick(8);
        chk("overflow_drained", exp_q.size(), 0);
        chk("overflow_empty", evt_valid, 0);

        evt_ready = 1'b0;
        set_touch(1'b1);
        repeat (4) strobe(12'd70, 12'd80);
        tick();
        chk("pre_rst_valid", evt_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_valid", evt_valid, 0);
        chk("rst_async_ovf", overflow, 0);
        exp_q.delete();
        touching = 1'b0;
        tick(2);
        rst = 1'b0; evt_ready = 1'b1;
        vs0 = valid_seen;
        tick(2 * DEB);
        chk("no_release_after_rst", valid_seen, vs0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/touch_event_filter.md
Name: touch_event_filter

Overview:
- Sits directly downstream of touch_controller and consumes its raw touching level, coordinate strobe and 12-bit X/Y samples.
- Debounces pen contact and averages coordinate samples.
- Emits discrete PRESS/MOVE/RELEASE events into a small FWFT FIFO, drained by the processor side with a valid/ready handshake.
- Runs on the 50 MHz touch clock domain.

Parameters:
- COORD_W, 12, coordinate width in bits.
- AVG_LOG2, 2, log2 of samples per averaged point (4 samples).
- DEB_CYCLES, 50000, clk cycles a touching level must hold stable before it is accepted (1 ms at 50 MHz).
- MOVE_THRESH, 8, minimum per-axis delta (strictly greater than) for a MOVE event.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- touching  in  1  raw pen-contact level from touch_controller
- sample_stb  in  1  one-cycle pulse; x_in/y_in valid this cycle
- x_in  in  COORD_W  raw X sample
- y_in  in  COORD_W  raw Y sample
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid && evt_ready
- evt_type  out  2  event type: 1=PRESS, 2=MOVE, 3=RELEASE (0 is never emitted)
- evt_x  out  COORD_W  averaged X of the event
- evt_y  out  COORD_W  averaged Y of the event
- overflow  out  1  sticky; set when an event is dropped on a full FIFO
- clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync deassert):
  - State is UP.
  - All counters and accumulators are 0; FIFO is empty.
  - evt_valid, evt_type, evt_x, evt_y and overflow are all 0.
- Debounce:
  - deb_cnt counts clk cycles while touching differs from the accepted level.
  - At DEB_CYCLES-1 the accepted level flips and deb_cnt clears.
  - Any agreement between touching and the accepted level clears deb_cnt.
- FSM states: UP, FIRST, DOWN.
  - UP -> FIRST when the accepted level rises; accumulators clear.
  - FIRST: accumulate sample_stb samples. When sample 2^AVG_LOG2 arrives, compute the average = accumulator >> AVG_LOG2 (truncate). Push PRESS with that average, store it as last_xy, go to DOWN.
  - DOWN: each completed average is compared with last_xy. If |dx| > MOVE_THRESH or |dy| > MOVE_THRESH, push MOVE and update last_xy; otherwise discard. Accumulator restarts after every completed average.
  - FIRST -> UP on accepted-level fall: no event; the partial accumulation is discarded.
  - DOWN -> UP on accepted-level fall: push RELEASE with last_xy; the partial accumulation is discarded.
- Timing and arithmetic:
  - Accumulators are COORD_W+AVG_LOG2 bits wide and cannot overflow.
  - sample_stb while in UP is ignored.
  - A sample_stb in the same cycle as the accepted-level fall is ignored; RELEASE takes priority.
  - Push latency: an event is visible at evt_valid on the cycle after the completing sample_stb or level change.
- FIFO:
  - First-word-fall-through; head fields are registered.
  - Pop occurs when evt_valid && evt_ready.
  - Simultaneous push and pop while full: pop is evaluated first and the push succeeds.
  - Push while full without pop: the event is dropped and overflow is set.
  - Simultaneous push and pop while empty: the event appears at the head next cycle with no loss.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- overflow: clear_ovf clears it. If clear_ovf coincides with a new drop, set wins.
- Reset mid-gesture: everything returns to reset values; no RELEASE is emitted.

Optional Feature:
- TOUCH_FILTER_MOVE_EN
  - Defined: MOVE events are generated as above.
  - Undefined: DOWN still averages and updates nothing. Only PRESS and RELEASE are emitted; RELEASE carries the PRESS coordinate. The MOVE_THRESH compare logic is not built.

Decomposition:
- Package touch_pkg holds:
  - enum evt_type_e {EVT_NONE=0, EVT_PRESS=1, EVT_MOVE=2, EVT_RELEASE=3}
  - packed struct touch_evt_t {evt_type_e type; logic [11:0] x, y;}
  - FSM state enum.
- Sub-module touch_evt_fifo: generic FWFT FIFO of touch_evt_t with push/pop/full/empty, parameter DEPTH.

Test Plan:
- Reset with touching=0 -> all outputs 0, overflow=0; evt_valid stays 0 for 10000 cycles.
- touching=1 held 50000 cycles, then 4 strobes x=100,102,104,106 / y=200 each -> one PRESS with x=103, y=200 one cycle after the 4th strobe.
- touching pulses 1 for 30000 cycles then 0 -> no event, state stays UP.
- After a PRESS at (103,200): averages (110,200) then (120,205), then touching=0 for 50000 cycles -> no event for (110,200) (delta 7), MOVE at (120,205), RELEASE at (120,205). With TOUCH_FILTER_MOVE_EN undefined: RELEASE at (103,200) and no MOVE.
- evt_ready=0, generate 5 events -> 4 queued, 5th dropped, overflow=1. Drain in order, then clear_ovf -> overflow=0.
- FIFO full with push and pop in the same cycle -> no drop, count stays 4. Assert rst mid-DOWN -> evt_valid=0 immediately, no RELEASE afterwards.
